// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the accumulator register file and its
// saved-accumulator stack.
package rf_pkg;
    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NREGS     = 8;
    localparam int DEF_RES_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    // index width for an n-entry array (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // counter width able to hold the value n itself
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/res_stack.sv
// LIFO of saved accumulator values with push, pop and push+pop swap.
// Reports a one-cycle error for push-on-full and pop-on-empty.
module res_stack
    import rf_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_RES_DEPTH,
    localparam int DW    = cnt_w(DEPTH),
    localparam int IW    = idx_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_top,
    output logic             o_pop_ok,
    output logic             o_err,
    output logic [DW-1:0]    o_depth,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_stk [2**IW];
    logic [DW-1:0]    r_depth;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_push_idx;

    assign w_top_idx  = IW'(r_depth - 1'b1);
    assign w_push_idx = IW'(r_depth);
    assign o_empty    = (r_depth == '0);
    assign o_full     = (r_depth == DW'(DEPTH));
    assign o_depth    = r_depth;
    assign o_top      = r_stk[w_top_idx];
    assign o_pop_ok   = i_pop & ~o_empty;
    // push+pop on an empty stack counts only as a bad pop
    assign o_err      = (i_pop & o_empty) | (i_push & ~i_pop & o_full);

    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2**IW; i++) r_stk[i] <= '0;
            r_depth <= '0;
        end else if (o_pop_ok) begin
            if (i_push) r_stk[w_top_idx] <= i_din;
            else        r_depth <= r_depth - 1'b1;
        end else if (i_push && !i_pop && !o_full) begin
            r_stk[w_push_idx] <= i_din;
            r_depth           <= r_depth + 1'b1;
        end
    end
endmodule

// File: rtl/accum_reg_file.sv
// Register array plus accumulator with copy-in/out, memory load, a saved-res
// stack and a sequential clear engine; all state changes on the falling edge.
module accum_reg_file
    import rf_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int NREGS     = DEF_NREGS,
    parameter  int RES_DEPTH = DEF_RES_DEPTH,
    localparam int SELW      = idx_w(NREGS),
    localparam int DW        = cnt_w(RES_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [SELW-1:0]  i_reg_sel,
    input  logic             i_cpyin,
    input  logic             i_cpyout,
    input  logic             i_mem_load,
    input  logic             i_res_we,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clr_req,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_reg_val,
    output logic [WIDTH-1:0] o_res_val,
    output logic [WIDTH-1:0] o_cone_reg,
    output logic [WIDTH-1:0] o_ctwo_reg,
    output logic [DW-1:0]    o_stk_depth,
    output logic             o_stk_full,
    output logic             o_stk_empty,
    output logic             o_busy,
    output logic             o_clr_done,
    output logic             o_err
);
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_res;
    clr_state_e       r_state;
    logic [SELW-1:0]  r_idx;
    logic             r_err;

    logic             w_busy;
    logic             w_pop_ok;
    logic             w_stk_err;
    logic [WIDTH-1:0] w_stk_top;

    res_stack #(.WIDTH(WIDTH), .DEPTH(RES_DEPTH)) u_stk (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_push   (i_push),
        .i_pop    (i_pop),
        .i_din    (r_res),
        .o_top    (w_stk_top),
        .o_pop_ok (w_pop_ok),
        .o_err    (w_stk_err),
        .o_depth  (o_stk_depth),
        .o_full   (o_stk_full),
        .o_empty  (o_stk_empty)
    );

    assign w_busy     = (r_state != ST_IDLE);
    assign o_busy     = w_busy;
    assign o_clr_done = (r_state == ST_DONE);
    assign o_err      = r_err;
    assign o_res_val  = r_res;
    assign o_reg_val  = r_regs[i_reg_sel];
    assign o_cone_reg = r_regs[SELW'(NREGS-2)];
    assign o_ctwo_reg = r_regs[SELW'(NREGS-1)];

    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_res   <= '0;
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_clr_req) begin
                    r_state <= ST_CLEAR;
                    r_idx   <= '0;
                end
                ST_CLEAR: begin
                    r_regs[r_idx] <= '0;
                    r_idx         <= r_idx + 1'b1;
                    if (r_idx == SELW'(NREGS-1)) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            // single write port; the clear engine owns the array while busy
            if (!w_busy) begin
                if (i_mem_load)    r_regs[i_reg_sel] <= i_write_data;
                else if (i_cpyout) r_regs[i_reg_sel] <= r_res;
            end

            if (w_pop_ok)      r_res <= w_stk_top;
            else if (i_cpyin)  r_res <= r_regs[i_reg_sel];
            else if (i_res_we) r_res <= i_write_data;

            r_err <= (r_err & ~i_err_clr) | w_stk_err
                   | (w_busy & (i_mem_load | i_cpyout));
        end
    end
endmodule

// File: tb/tb_accum_reg_file.sv
// Directed walk through the main features followed by random traffic, all
// checked against a queue-based behavioural model of the register file.
module tb_accum_reg_file;
    localparam int W  = 16;
    localparam int NR = 8;
    localparam int RD = 4;
    localparam int SW = 3;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n, cpyin, cpyout, mem_load, res_we, push, pop, clr_req, err_clr;
    logic [SW-1:0] reg_sel;
    logic [W-1:0]  wd;
    logic [W-1:0]  reg_val, res_val, cone_reg, ctwo_reg;
    logic [DW-1:0] stk_depth;
    logic          stk_full, stk_empty, busy, clr_done, err;

    always #5 clk = ~clk;

    accum_reg_file #(.WIDTH(W), .NREGS(NR), .RES_DEPTH(RD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_reg_sel(reg_sel), .i_cpyin(cpyin),
        .i_cpyout(cpyout), .i_mem_load(mem_load), .i_res_we(res_we),
        .i_write_data(wd), .i_push(push), .i_pop(pop), .i_clr_req(clr_req),
        .i_err_clr(err_clr), .o_reg_val(reg_val), .o_res_val(res_val),
        .o_cone_reg(cone_reg), .o_ctwo_reg(ctwo_reg), .o_stk_depth(stk_depth),
        .o_stk_full(stk_full), .o_stk_empty(stk_empty), .o_busy(busy),
        .o_clr_done(clr_done), .o_err(err)
    );

    // reference model
    logic [W-1:0] m_regs [NR];
    logic [W-1:0] m_res;
    logic [W-1:0] m_stk [$];
    int           m_phase;   // -1 idle, 0..NR-1 clearing that register, NR done
    bit           m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] old_res, rd, top;
        bit           was_busy, e, popped;
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_res = '0; m_stk.delete(); m_phase = -1; m_err = 0;
            return;
        end
        old_res = m_res; rd = m_regs[reg_sel]; was_busy = (m_phase >= 0);
        e = 0; popped = 0;
        if (m_phase >= 0 && m_phase < NR) m_regs[m_phase] = '0;
        if (mem_load || cpyout) begin
            if (was_busy) e = 1;
            else m_regs[reg_sel] = mem_load ? wd : old_res;
        end
        if (m_phase < 0) begin
            if (clr_req) m_phase = 0;
        end else if (m_phase < NR) m_phase++;
        else m_phase = -1;
        if (pop && m_stk.size() == 0) e = 1;
        else if (pop) begin
            top = m_stk[$];
            if (push) m_stk[$] = old_res;
            else void'(m_stk.pop_back());
            m_res = top; popped = 1;
        end else if (push) begin
            if (m_stk.size() == RD) e = 1;
            else m_stk.push_back(old_res);
        end
        if (!popped) begin
            if (cpyin) m_res = rd;
            else if (res_we) m_res = wd;
        end
        m_err = (m_err && !err_clr) || e;
    endtask

    task automatic check_all();
        chk("res_val",   res_val,   m_res);
        chk("reg_val",   reg_val,   m_regs[reg_sel]);
        chk("cone_reg",  cone_reg,  m_regs[NR-2]);
        chk("ctwo_reg",  ctwo_reg,  m_regs[NR-1]);
        chk("stk_depth", stk_depth, m_stk.size());
        chk("stk_full",  stk_full,  m_stk.size() == RD);
        chk("stk_empty", stk_empty, m_stk.size() == 0);
        chk("busy",      busy,      m_phase >= 0);
        chk("clr_done",  clr_done,  m_phase == NR);
        chk("err",       err,       m_err);
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_in();
        rst_n = 1; cpyin = 0; cpyout = 0; mem_load = 0; res_we = 0;
        push = 0; pop = 0; clr_req = 0; err_clr = 0;
    endtask

    int n_busy, done_at;

    initial begin
        idle_in(); reg_sel = '0; wd = '0;
        rst_n = 0; cyc(); cyc();
        chk("rst_empty", stk_empty, 1'b1);
        chk("rst_busy", busy, 1'b0);

        // load and copy-in
        idle_in(); reg_sel = 3; mem_load = 1; wd = 16'h1234; cyc();
        idle_in(); cpyin = 1; cyc();
        chk("cpyin_res", res_val, 16'h1234);
        chk("cpyin_reg", reg_val, 16'h1234);
        chk("cone_zero", cone_reg, 16'h0);

        // write priority
        idle_in(); res_we = 1; wd = 16'h00AA; cyc();
        idle_in(); reg_sel = 6; mem_load = 1; cpyout = 1; wd = 16'h5555; cyc();
        chk("prio_ml", cone_reg, 16'h5555);
        idle_in(); cpyout = 1; cyc();
        chk("prio_co", cone_reg, 16'h00AA);

        // fill, overflow, drain, underflow
        for (int v = 1; v <= 4; v++) begin
            idle_in(); res_we = 1; wd = W'(v); cyc();
            idle_in(); push = 1; cyc();
        end
        chk("stk_full4", stk_full, 1'b1);
        idle_in(); push = 1; cyc();
        chk("ovf_err", err, 1'b1);
        chk("ovf_depth", stk_depth, 3'd4);
        for (int v = 4; v >= 1; v--) begin
            idle_in(); pop = 1; cyc();
            chk("pop_res", res_val, W'(v));
        end
        idle_in(); pop = 1; cyc();
        chk("udf_res", res_val, 16'h1);
        chk("udf_empty", stk_empty, 1'b1);

        // swap
        idle_in(); err_clr = 1; cyc();
        idle_in(); res_we = 1; wd = 16'h7; cyc();
        idle_in(); push = 1; cyc();
        idle_in(); res_we = 1; wd = 16'h9; cyc();
        idle_in(); push = 1; pop = 1; cyc();
        chk("swap_res", res_val, 16'h7);
        chk("swap_depth", stk_depth, 3'd1);
        idle_in(); pop = 1; cyc();
        chk("swap_top", res_val, 16'h9);

        // clear sequence with a blocked write in the middle
        for (int i = 0; i < NR; i++) begin
            idle_in(); mem_load = 1; reg_sel = SW'(i); wd = W'(i + 1); cyc();
        end
        idle_in(); clr_req = 1; cyc();
        n_busy = busy ? 1 : 0; done_at = 0;
        for (int j = 2; j <= 11; j++) begin
            idle_in();
            if (j == 3) begin mem_load = 1; reg_sel = 2; wd = 16'hBEEF; end
            cyc();
            if (busy) n_busy++;
            if (clr_done) done_at = j;
        end
        chk("clr_busy_cycles", n_busy, 9);
        chk("clr_done_cycle", done_at, 9);
        chk("clr_wr_err", err, 1'b1);
        for (int i = 0; i < NR; i++) begin
            idle_in(); reg_sel = SW'(i); cyc();
            chk("clr_zero", reg_val, 16'h0);
        end

        // reset part-way through a clear
        idle_in(); err_clr = 1; cyc();
        idle_in(); clr_req = 1; cyc();
        idle_in(); cyc();
        idle_in(); rst_n = 0; cyc();
        chk("abort_busy", busy, 1'b0);
        chk("abort_res", res_val, 16'h0);

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            reg_sel  = SW'($urandom_range(0, NR - 1));
            wd       = W'($urandom);
            cpyin    = ($urandom_range(0, 99) < 15);
            cpyout   = ($urandom_range(0, 99) < 15);
            mem_load = ($urandom_range(0, 99) < 20);
            res_we   = ($urandom_range(0, 99) < 30);
            push     = ($urandom_range(0, 99) < 25);
            pop      = ($urandom_range(0, 99) < 20);
            clr_req  = ($urandom_range(0, 99) < 3);
            err_clr  = ($urandom_range(0, 99) < 12);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/accum_reg_file.md
# accum_reg_file

- Parametrised successor to the 8×16 accumulator register file.
- Holds NREGS general registers plus the accumulator `res`, with the same copy-in, copy-out and memory-load paths.
- New features:
  - a LIFO stack of saved accumulator values (push/pop), for nested expression evaluation;
  - a multi-cycle clear sequencer that zeroes the register array.
- Sits between the decoder/ALU and data memory in the datapath. The ALU writes `res`; data memory loads registers.

## Interface
Parameters:
- WIDTH, 16, data width of registers, res and stack entries
- NREGS, 8, register count (power of two, ≥4); SELW = log2(NREGS)
- RES_DEPTH, 4, accumulator stack entries (≥1)

Ports:
- clk  in  1  clock; all state updates on falling edge
- rst_n  in  1  reset, synchronous, active-low
- reg_sel  in  SELW  register select for read, copy-out and load
- cpyin  in  1  res ← reg[reg_sel]
- cpyout  in  1  reg[reg_sel] ← res
- mem_load  in  1  reg[reg_sel] ← write_data
- res_we  in  1  res ← write_data (ALU result)
- write_data  in  WIDTH  ALU/memory write data
- push  in  1  save res onto stack
- pop  in  1  restore res from stack top
- clr_req  in  1  start clear sequence
- err_clr  in  1  clear sticky err
- reg_val  out  WIDTH  reg[reg_sel], combinational
- res_val  out  WIDTH  res
- cone_reg  out  WIDTH  reg[NREGS-2]
- ctwo_reg  out  WIDTH  reg[NREGS-1]
- stk_depth  out  log2(RES_DEPTH)+1  valid stack entries
- stk_full, stk_empty  out  1  stack flags
- busy  out  1  clear sequencer active
- clr_done  out  1  one-cycle pulse when clear completes
- err  out  1  sticky error

## Operation
Register write port (one write per cycle):
- mem_load has priority over cpyout.
- Both are ignored while busy.

res update priority:
- pop, then cpyin, then res_we; otherwise res holds.
- This differs from the old block, where res defaulted to write_data every cycle.

Register/res interaction:
- cpyout with cpyin/res_we/pop in the same cycle: the register gets the old res; res gets the new value.

Stack (LIFO):
- push: stack[top] ← old res, depth+1. A simultaneous res update still applies.
- pop: res ← top entry, depth−1.
- push and pop together, depth ≥1: swap, i.e. res ← top, top ← old res, depth unchanged.
- push and pop together, depth 0: treated as pop on empty.
- push when full: stack unchanged, err set.
- pop when empty: res unchanged, err set; lower-priority res sources still apply.

Clear sequencer states:
- IDLE: clr_req → CLEAR, idx=0.
- CLEAR: reg[idx] ← 0, idx+1; after idx=NREGS-1 → DONE. res and stack are untouched.
- DONE: clr_done=1 → IDLE.

Clear rules:
- clr_req outside IDLE is ignored.
- A write attempt (cpyout/mem_load) while busy sets err.
- Reads (reg_val), cpyin and the stack operate normally during clear. reg_val shows already-cleared registers as 0.

err:
- Set by any error condition above; held until err_clr.
- err_clr and a new error in the same cycle: err stays 1.

## Timing
- All writes take effect at the falling edge where the control is sampled. reg_val/res_val reflect them immediately after that edge.
- reg_val is a combinational read with no bypass: a write in cycle n is visible in cycle n+1.
- Clear: busy rises the edge after clr_req and stays high for NREGS cycles (CLEAR) plus 1 (DONE). clr_done coincides with the DONE cycle. Total NREGS+1 cycles.
- Reset (rst_n low at a falling edge) values:
  - all registers, res and stack entries 0;
  - depth 0, stk_empty=1, stk_full=0;
  - state IDLE, busy=0, clr_done=0, err=0.
- Reset mid-clear aborts to IDLE with everything zeroed.

## Structure
- Package rf_pkg holds:
  - clear FSM state enum (IDLE/CLEAR/DONE);
  - default parameter constants;
  - a clog2-based width helper for SELW and stk_depth.
- One sub-module, res_stack, is natural: parametrised LIFO with push/pop/swap, full/empty/depth and an error output.
- The register array, write-port arbitration and clear FSM stay in accum_reg_file.

## Test plan
- Reset, then mem_load reg_sel=3 with 0x1234; cpyin sel=3 → res_val=0x1234, reg_val(3)=0x1234; cone_reg/ctwo_reg=0.
- Write priority: mem_load and cpyout together to reg 6 (res=0x00AA, write_data=0x5555) → cone_reg=0x5555. Next cycle cpyout alone → reg6=0x00AA.
- Stack with RES_DEPTH=4:
  - 4 pushes of res=1..4 → stk_full=1; 5th push → err=1, depth 4.
  - 4 pops → res 4,3,2,1, stk_empty=1; extra pop → res stays 1, err held.
- Swap: depth=1 (top=7), res=9, push and pop together → res=7, top=9, depth 1.
- Clear after loading reg0..7 = 1..8:
  - clr_req → busy for 9 cycles, clr_done pulses in cycle 9, all regs 0.
  - mem_load mid-clear → ignored, err=1.
- Reset asserted in cycle 3 of clear → busy=0, all outputs at reset values next cycle.
